// File: rtl/mem_pkg.sv
// Shared memory-access definitions: op codes, address map, entry layout and
// the combinational legality and lane-encoding helpers used by the store path.
package mem_pkg;

    localparam logic [3:0] MEMOP_W = 4'd1;
    localparam logic [3:0] MEMOP_H = 4'd2;
    localparam logic [3:0] MEMOP_B = 4'd3;

    localparam logic [31:0] DM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DM_LIMIT  = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE  = 32'h0000_7F00;
    localparam logic [31:0] TC0_LIMIT = 32'h0000_7F0B;
    localparam logic [31:0] TC1_BASE  = 32'h0000_7F10;
    localparam logic [31:0] TC1_LIMIT = 32'h0000_7F1B;
    localparam logic [31:0] IG_BASE   = 32'h0000_7F20;
    localparam logic [31:0] IG_LIMIT  = 32'h0000_7F23;

    localparam logic [31:0] TC_COUNT_OFS = 32'h0000_0008;

    typedef logic [3:0] byteen_t;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        byteen_t     byteen;
    } st_entry_t;

    localparam int ST_ENTRY_W = $bits(st_entry_t);

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == MEMOP_W) || (op == MEMOP_H) || (op == MEMOP_B);
    endfunction

    function automatic logic addr_legal(input logic [31:0] addr);
        return in_range(addr, DM_BASE, DM_LIMIT)
            || in_range(addr, TC0_BASE, TC0_LIMIT)
            || in_range(addr, TC1_BASE, TC1_LIMIT)
            || in_range(addr, IG_BASE, IG_LIMIT);
    endfunction

    // Both timer blocks plus the hole between them; only word access is allowed here.
    function automatic logic in_timer_window(input logic [31:0] addr);
        return in_range(addr, TC0_BASE, TC1_LIMIT);
    endfunction

    function automatic logic in_tc_count(input logic [31:0] addr);
        return in_range(addr, TC0_BASE + TC_COUNT_OFS, TC0_LIMIT)
            || in_range(addr, TC1_BASE + TC_COUNT_OFS, TC1_LIMIT);
    endfunction

    function automatic logic misaligned(input logic [3:0]  op,
                                        input logic [31:0] addr);
        logic result;
        result = 1'b0;
        if (op == MEMOP_W) begin
            result = (addr[1:0] != 2'b00);
        end else if (op == MEMOP_H) begin
            result = addr[0];
        end
        return result;
    endfunction

    function automatic logic store_ades(input logic [3:0]  op,
                                        input logic [31:0] addr,
                                        input logic        ov);
        logic result;
        result = 1'b0;
        if (is_store_op(op)) begin
            result = ov
                  || misaligned(op, addr)
                  || !addr_legal(addr)
                  || ((op != MEMOP_W) && in_timer_window(addr))
                  || in_tc_count(addr);
        end
        return result;
    endfunction

    function automatic st_entry_t store_encode(input logic [3:0]  op,
                                               input logic [31:0] addr,
                                               input logic [31:0] d);
        st_entry_t e;
        e.waddr  = addr[31:2];
        e.wdata  = d;
        e.byteen = 4'b0000;
        case (op)
            MEMOP_W: begin
                e.wdata  = d;
                e.byteen = 4'b1111;
            end
            MEMOP_H: begin
                e.wdata  = {d[15:0], d[15:0]};
                e.byteen = addr[1] ? 4'b1100 : 4'b0011;
            end
            MEMOP_B: begin
                e.wdata  = {4{d[7:0]}};
                e.byteen = 4'b0001 << addr[1:0];
            end
            default: begin
                e.byteen = 4'b0000;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Small valid/ready FIFO with register entries; the read port reads zero when
// empty so downstream never sees stale head data.
module store_fifo #(
    parameter int W     = 66,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_valid_i,
    output logic         wr_ready_o,
    input  logic [W-1:0] wr_data_i,
    output logic         rd_valid_o,
    input  logic         rd_ready_i,
    output logic [W-1:0] rd_data_o,
    output logic         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    // Readiness depends only on the registered count: no full-buffer bypass.
    assign wr_ready_o = (count_q != CNT_W'(DEPTH));
    assign rd_valid_o = (count_q != '0);
    assign empty_o    = (count_q == '0);
    assign wr_en      = wr_valid_i & wr_ready_o;
    assign rd_en      = rd_valid_o & rd_ready_i;
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_q[gi] <= '0;
                end else if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= wr_data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/store_encoder.sv
// M-stage store unit: flags address exceptions, encodes accepted stores into
// word-aligned data plus byte enables, and buffers them toward the data bus.
module store_encoder
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [3:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic        st_ov,
    output logic        st_ready,
    output logic        exc_ades,
    output logic        m_data_valid,
    input  logic        m_data_ready,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic        sb_empty
);

    st_entry_t enc_entry;
    st_entry_t head_entry;
    logic      enq_valid;

    // Exception check is purely combinational and independent of buffer state.
    assign exc_ades  = store_ades(st_op, st_addr, st_ov);
    assign enc_entry = store_encode(st_op, st_addr, st_wdata);
    assign enq_valid = st_valid & is_store_op(st_op) & ~exc_ades;

    store_fifo #(
        .W     (ST_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_valid_i (enq_valid),
        .wr_ready_o (st_ready),
        .wr_data_i  (enc_entry),
        .rd_valid_o (m_data_valid),
        .rd_ready_i (m_data_ready),
        .rd_data_o  (head_entry),
        .empty_o    (sb_empty)
    );

    assign m_data_addr   = {head_entry.waddr, 2'b00};
    assign m_data_wdata  = head_entry.wdata;
    assign m_data_byteen = head_entry.byteen;

endmodule
